// File: rtl/fifo_spi_serializer_if.sv
// Pin bundle between the serializer, the upstream FIFO read port and the SPI pads.
// master = serializer side, slave = FIFO/pad side.
interface fifo_spi_serializer_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_empty;
   logic                  fifo_rd_en;
   logic                  sclk;
   logic                  mosi;
   logic                  cs_n;

   modport master (
      input  fifo_rd_data,
      input  fifo_empty,
      output fifo_rd_en,
      output sclk,
      output mosi,
      output cs_n
   );

   modport slave (
      output fifo_rd_data,
      output fifo_empty,
      input  fifo_rd_en,
      input  sclk,
      input  mosi,
      input  cs_n
   );
endinterface

// File: rtl/fifo_spi_serializer.sv
// Pops words from a registered-read FIFO and shifts each one out MSB-first as one
// SPI mode-0 frame (sclk idle low, mosi updated on the falling edge), with a cs_n gap.
module fifo_spi_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int CLK_DIV    = 4,
   parameter int CS_GAP     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   fifo_spi_serializer_if.master  bus,
   output logic                   busy,
   output logic [31:0]            words_sent,
   output logic                   underflow
);

   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_GAP
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic                  cs_n_q, cs_n_d;
   logic                  empty_q;
   logic                  underflow_q, underflow_d;
   logic [31:0]           words_sent_q;
   logic [31:0]           words_sent_d;
   logic                  word_done;
   logic                  ready;
   logic                  div_last;
   logic                  gap_last;

   // A word written into an empty FIFO is only readable one cycle after the flag drops,
   // so the delayed flag must also show non-empty before a fetch is allowed.
   assign ready    = enable & ~bus.fifo_empty & ~empty_q;
   assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));
   assign gap_last = (gap_cnt_q == GAP_W'(CS_GAP - 1));

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      cs_n_d      = cs_n_q;
      underflow_d = underflow_q;
      word_done   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b0;
            if (ready) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            shreg_d   = bus.fifo_rd_data;
            bit_cnt_d = BIT_W'(DATA_WIDTH - 1);
            div_cnt_d = '0;
            cs_n_d    = 1'b0;
            mosi_d    = bus.fifo_rd_data[DATA_WIDTH-1];
            state_d   = ST_SHIFT;
         end

         ST_SHIFT: begin
            if (div_last) begin
               div_cnt_d = '0;
               sclk_d    = ~sclk_q;
               // Data only moves on the falling edge; the rising edge is the sample point.
               if (sclk_q) begin
                  if (bit_cnt_q == '0) begin
                     cs_n_d    = 1'b1;
                     mosi_d    = 1'b0;
                     word_done = 1'b1;
                     gap_cnt_d = '0;
                     state_d   = ST_GAP;
                  end else begin
                     shreg_d   = shreg_q << 1;
                     mosi_d    = shreg_q[DATA_WIDTH-2];
                     bit_cnt_d = bit_cnt_q - BIT_W'(1);
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         ST_GAP: begin
            cs_n_d = 1'b1;
            if (gap_last) begin
               if (enable && bus.fifo_empty) begin
                  underflow_d = 1'b1;
               end
               state_d = ready ? ST_FETCH : ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign words_sent_d = word_done ? (words_sent_q + 32'd1) : words_sent_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         div_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         empty_q      <= 1'b1;
         underflow_q  <= 1'b0;
         words_sent_q <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         div_cnt_q    <= div_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         cs_n_q       <= cs_n_d;
         empty_q      <= bus.fifo_empty;
         underflow_q  <= underflow_d;
         words_sent_q <= words_sent_d;
      end
   end

   assign bus.fifo_rd_en = (state_q == ST_FETCH);
   assign bus.sclk       = sclk_q;
   assign bus.mosi       = mosi_q;
   assign bus.cs_n       = cs_n_q;
   assign busy           = (state_q != ST_IDLE);
   assign words_sent     = words_sent_q;
   assign underflow      = underflow_q;

endmodule
